alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply / restoring-divide unit with RISC-V sign and corner-case handling.
// Optional build macro MULDIV_EARLY_OUT_EN enables early termination; results are unchanged.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam logic [4:0] OpMul    = 5'b00010;
    localparam logic [4:0] OpMulh   = 5'b00011;
    localparam logic [4:0] OpMulhsu = 5'b00100;
    localparam logic [4:0] OpMulhu  = 5'b00101;
    localparam logic [4:0] OpDiv    = 5'b00110;
    localparam logic [4:0] OpDivu   = 5'b00111;
    localparam logic [4:0] OpRem    = 5'b01000;
    localparam logic [4:0] OpRemu   = 5'b01001;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 bypass_q, bypass_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 div_zero_q, div_zero_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]     mplier_q, mplier_d;
`endif

    // Accept-side decode
    logic             op_is_mul, op_is_div, a_signed, b_signed, a_neg, b_neg;
    logic             b_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_is_mul = opcode inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
    assign op_is_div = opcode inside {OpDiv, OpDivu, OpRem, OpRemu};
    assign a_signed  = opcode inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    assign b_signed  = opcode inside {OpMul, OpMulh, OpDiv, OpRem};
    assign a_neg     = a_signed & src_a[WIDTH-1];
    assign b_neg     = b_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;
    assign b_zero    = (src_b == '0);
    assign div_ovf   = (opcode inside {OpDiv, OpRem}) && (src_a == MinVal) && (src_b == '1);

    // One iteration of each datapath
    logic             calc_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_sub, rem_next;

    assign calc_div  = op_q inside {OpDiv, OpDivu, OpRem, OpRemu};
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
    assign rem_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge    = rem_shift >= {1'b0, opnd_q};
    assign rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
    assign rem_next  = div_ge ? rem_sub : rem_shift[WIDTH-1:0];

    // Sign correction; an early-exited multiply still owes cnt_q right shifts
    logic [2*WIDTH-1:0] full, full_neg, mul_val;
    logic [WIDTH-1:0]   quot, rem, fix_val;

`ifdef MULDIV_EARLY_OUT_EN
    assign full = prod_q >> cnt_q;
`else
    assign full = prod_q;
`endif
    assign full_neg = -full;
    assign mul_val  = neg_q ? full_neg : full;
    assign quot     = full[WIDTH-1:0];
    assign rem      = full[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_val = '0;
        if (bypass_q) begin
            fix_val = prod_q[WIDTH-1:0];
        end else begin
            unique case (op_q)
                OpMul:                     fix_val = mul_val[WIDTH-1:0];
                OpMulh, OpMulhsu, OpMulhu: fix_val = mul_val[2*WIDTH-1:WIDTH];
                OpDiv, OpDivu:             fix_val = neg_q ? -quot : quot;
                OpRem, OpRemu:             fix_val = neg_q ? -rem : rem;
                default:                   fix_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        bypass_d   = bypass_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        opnd_d     = opnd_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_EARLY_OUT_EN
        mplier_d   = mplier_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d       = opcode;
                    bypass_d   = 1'b0;
                    div_zero_d = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                    state_d    = StCalc;
`ifdef MULDIV_EARLY_OUT_EN
                    mplier_d   = b_mag;
`endif
                    if (op_is_div) begin
                        neg_d  = (opcode == OpRem) ? a_neg : (a_neg ^ b_neg);
                        prod_d = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        neg_d  = a_neg ^ b_neg;
                        prod_d = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end

                    if (!op_is_mul && !op_is_div) begin
                        bypass_d = 1'b1;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = StFix;
                    end else if (op_is_div && b_zero) begin
                        bypass_d   = 1'b1;
                        div_zero_d = 1'b1;
                        prod_d     = {{WIDTH{1'b0}},
                                      ((opcode inside {OpDiv, OpDivu}) ? {WIDTH{1'b1}} : src_a)};
                        cnt_d      = '0;
                        state_d    = StFix;
                    end else if (div_ovf) begin
                        bypass_d = 1'b1;
                        prod_d   = {{WIDTH{1'b0}}, ((opcode == OpDiv) ? MinVal : {WIDTH{1'b0}})};
                        cnt_d    = '0;
                        state_d  = StFix;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (op_is_div && (a_mag < b_mag)) begin
                        // Quotient 0, remainder is the dividend; normal sign fix applies
                        prod_d  = {a_mag, {WIDTH{1'b0}}};
                        cnt_d   = '0;
                        state_d = StFix;
`endif
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (calc_div) begin
                    prod_d = {rem_next, prod_q[WIDTH-2:0], div_ge};
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
`ifdef MULDIV_EARLY_OUT_EN
                mplier_d = mplier_q >> 1;
                if (!calc_div && (mplier_d == '0)) begin
                    state_d = StFix;
                end
`endif
            end
            StFix: begin
                result_d = fix_val;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            neg_q      <= 1'b0;
            bypass_q   <= 1'b0;
            cnt_q      <= '0;
            prod_q     <= '0;
            opnd_q     <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            bypass_q   <= bypass_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            opnd_q     <= opnd_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q   <= mplier_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised self-checking bench for alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [4:0]   opcode = '0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         in_ready, out_valid, div_zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .div_zero (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics plus the documented latency rules
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dz, output int lat);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        logic            special, sgn_a, sgn_b;
        logic [31:0]     mag_a, mag_b;
        int              n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        dz = 1'b0;
        res = '0;
        special = 1'b0;
        case (op)
            5'd2: begin p = sa * sb; res = p[31:0]; end
            5'd3: begin p = sa * sb; res = p[63:32]; end
            5'd4: begin p = sa * longint'(ub); res = p[63:32]; end
            5'd5: begin pu = ua * ub; res = pu[63:32]; end
            5'd6, 5'd8: begin
                if (b == 0) begin
                    dz = 1'b1; special = 1'b1;
                    res = (op == 5'd6) ? 32'hFFFF_FFFF : a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    special = 1'b1;
                    res = (op == 5'd6) ? 32'h8000_0000 : 32'h0;
                end else begin
                    p = (op == 5'd6) ? sa / sb : sa % sb;
                    res = p[31:0];
                end
            end
            5'd7, 5'd9: begin
                if (b == 0) begin
                    dz = 1'b1; special = 1'b1;
                    res = (op == 5'd7) ? 32'hFFFF_FFFF : a;
                end else begin
                    res = (op == 5'd7) ? a / b : a % b;
                end
            end
            default: special = 1'b1;
        endcase
        lat = special ? 2 : W + 2;
        sgn_a = (op inside {5'd2, 5'd3, 5'd4, 5'd6, 5'd8}) && a[31];
        sgn_b = (op inside {5'd2, 5'd3, 5'd6, 5'd8}) && b[31];
        mag_a = sgn_a ? 32'(0 - ua) : a;
        mag_b = sgn_b ? 32'(0 - ub) : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (!special) begin
            if (op inside {5'd2, 5'd3, 5'd4, 5'd5}) begin
                n = 0;
                for (int i = 0; i < 32; i++) if (mag_b[i]) n = i + 1;
                lat = ((n < 1) ? 1 : n) + 2;
            end else if (mag_a < mag_b) begin
                lat = 2;
            end
        end
`else
        n = int'(mag_a ^ mag_b);  // magnitudes only matter for the early-out build
`endif
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] er, first;
        logic        edz;
        int          elat, lat;
        model(op, a, b, er, edz, elat);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; opcode = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 64'(out_valid), 64'(1));
            @(negedge clk); flush = 1'b1;
            @(negedge clk); flush = 1'b0;
            return;
        end
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(edz));
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        first = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_result"}, 64'(result), 64'(first));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        end
        // Request held during the handshake must not be taken in that cycle
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_post_valid"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        logic [4:0] rop;
        int r;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_div_zero", 64'(div_zero), 64'(0));
        @(negedge clk); rst = 1'b0;

        run_op("div_m7_2", 5'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 5'd8, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("mulh_min", 5'd3, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhsu_m1", 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu_max", 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_6_m3", 5'd2, 32'd6, 32'hFFFF_FFFD, 0);
        run_op("divu_5_0", 5'd7, 32'd5, 32'd0, 0);
        run_op("rem_5_0", 5'd8, 32'd5, 32'd0, 0);
        run_op("div_ovf", 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("bad_op", 5'd17, 32'd9, 32'd9, 0);
        run_op("mul_5_1", 5'd2, 32'd5, 32'd1, 0);
        run_op("divu_3_10", 5'd7, 32'd3, 32'd10, 0);
        run_op("remu_3_10", 5'd9, 32'd3, 32'd10, 0);
        run_op("hold_mul", 5'd2, 32'd1234, 32'd5678, 10);

        // Flush at CALC cycle 10
        @(negedge clk);
        in_valid = 1'b1; opcode = 5'd7; src_a = 32'hFFFF_FFFF; src_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flush_in_ready", 64'(in_ready), 64'(1));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk); flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("flush_no_valid", 64'(seen), 64'(0));

        // flush beats in_valid in IDLE
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; opcode = 5'd2; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        check("flush_wins_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        run_op("mulhu_3_4", 5'd5, 32'd3, 32'd4, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            rop = (r < 8) ? 5'(r + 2) : ((r == 8) ? 5'd0 : 5'd12);
            run_op("rand", rop, rand_opnd(), rand_opnd(), $urandom_range(0, 2));
        end

        // Reset mid-operation clears result as well
        run_op("pre_rst", 5'd7, 32'd100, 32'd7, 0);
        @(negedge clk);
        in_valid = 1'b1; opcode = 5'd7; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_result", 64'(result), 64'(0));
        @(negedge clk); rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
